seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It takes a 16-bit value plus four decimal-point bits, latches them only at frame boundaries so the display never tears, and scans one digit at a time with a blanking interval before each digit to suppress ghosting. It sits directly downstream of the debounced-input and counter logic. Each selected nibble is decoded through the team's hex-to-7-segment decoder, and the block drives the board's anode, segment and dp pins.

---
 rtl/seg7_scan_driver.sv | 232 +++++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - tear-free 4-digit multiplexed seven-segment scan driver (option: SEG7_LZB_EN)

// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module seg7_hex_decoder (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Pure lookup; a lit segment is driven low.
  always_comb begin
    seg_o = 7'h7F;
    case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// Scans digit 0..3, one slot of REFRESH_DIV cycles each, anodes off for the
// first BLANK_CYCLES of every slot. New values are only adopted at the
// frame boundary (digit 3 -> digit 0) so a frame never mixes two values.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        update,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam bit BLANK_EN = (BLANK_CYCLES != 0);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  // Without a blanking interval the scan never leaves DRIVE.
  localparam state_e ST_RESET = BLANK_EN ? ST_BLANK : ST_DRIVE;

  // Scan position
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    digit_q, digit_d;
  state_e        state_q, state_d;

  // Pending request and the value currently on the glass
  logic          pend_q, pend_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic [15:0]   disp_val_q, disp_val_d;
  logic [3:0]    disp_dp_q, disp_dp_d;

  // Registered pin drivers
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fd_q, fd_d;

  logic          wrap;
  logic          boundary;
  logic [3:0]    nibble_sel;
  logic [6:0]    seg_dec;
  logic [3:0]    anode_sel;
  logic          dp_sel;
  logic          lead_zero;

  assign wrap     = (cnt_q == CNT_LAST);
  assign boundary = wrap && (digit_q == 2'd3);

  // Slot counter and digit index advance.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    if (wrap) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
    end
  end

  // BLANK/DRIVE next-state; decisions use the upcoming count so the
  // registered outputs line up with the new position.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_d == CNT_BLANK) state_d = ST_DRIVE;
      ST_DRIVE: if (wrap && BLANK_EN) state_d = ST_BLANK;
      default:  state_d = ST_RESET;
    endcase
  end

  // Pending buffer and display register: an update on the boundary edge
  // itself bypasses the buffer; otherwise the latest request waits there.
  always_comb begin
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    if (boundary) begin
      if (update) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
      end else if (pend_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
      pend_d = 1'b0;
    end else if (update) begin
      pend_d     = 1'b1;
      pend_val_d = value;
      pend_dp_d  = dp_in;
    end
  end

  assign nibble_sel = disp_val_d[{digit_d, 2'b00} +: 4];
  assign anode_sel  = ~(4'b0001 << digit_d);
  assign dp_sel     = disp_dp_d[digit_d];

  seg7_hex_decoder u_dec (
    .nibble_i (nibble_sel),
    .seg_o    (seg_dec)
  );

`ifdef SEG7_LZB_EN
  // A digit above 0 is a leading zero when it and every digit left of it are 0.
  always_comb begin
    lead_zero = 1'b0;
    case (digit_d)
      2'd1:    lead_zero = (disp_val_d[15:4]  == 12'h000);
      2'd2:    lead_zero = (disp_val_d[15:8]  == 8'h00);
      2'd3:    lead_zero = (disp_val_d[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase
  end
`else
  assign lead_zero = 1'b0;
`endif

  // Pin values for the upcoming cycle; blank unless driving a digit.
  always_comb begin
    an_d = 4'hF;
    seg_d = 7'h7F;
    dp_d = 1'b1;
    fd_d = boundary;
    if (state_d == ST_DRIVE) begin
      dp_d = ~dp_sel;
      if (!lead_zero) begin
        an_d  = anode_sel;
        seg_d = seg_dec;
      end else if (dp_sel) begin
        // Suppressed digit still needs its anode so the decimal point shows.
        an_d = anode_sel;
      end
    end
  end

  // Scan position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      digit_q <= 2'd0;
      state_q <= ST_RESET;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      state_q <= state_d;
    end
  end

  // Value buffers; a reset discards any pending request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= 1'b0;
      pend_val_q <= 16'h0000;
      pend_dp_q  <= 4'h0;
      disp_val_q <= 16'h0000;
      disp_dp_q  <= 4'h0;
    end else begin
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
    end
  end

  // Output registers keep the pins free of combinational paths from inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
      fd_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fd_q  <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver with a frame-position reference model
module tb_seg7_scan_driver;

  localparam int RDIV  = 8;
  localparam int BLK   = 2;
  localparam int FRAME = 4 * RDIV;

  localparam logic [6:0] HEX7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        update = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  seg7_scan_driver #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLK)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .update     (update),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: edges since reset release, shown and pending values.
  int unsigned n_cyc = 0;
  logic [15:0] m_val = 16'h0, m_pval = 16'h0;
  logic [3:0]  m_dp = 4'h0, m_pdp = 4'h0;
  logic        m_pend = 1'b0;

  // Expected pins from frame position: slot k = p / RDIV, offset c = p % RDIV.
  function automatic obs_t model_out(int unsigned n, logic [15:0] v, logic [3:0] d);
    obs_t o;
    int p, k, c;
    logic [3:0] nib;
    bit lz;
    o = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
    p = int'(n % FRAME);
    k = p / RDIV;
    c = p % RDIV;
    o.fd = (n != 0) && (p == 0);
    if (c >= BLK) begin
      nib = 4'((v >> (4 * k)) & 16'hF);
      lz = 1'b0;
`ifdef SEG7_LZB_EN
      lz = (k > 0) && ((v >> (4 * k)) == 16'h0);
`endif
      o.dp = ~d[k];
      if (!lz) begin
        o.an  = ~(4'(1) << k);
        o.seg = HEX7[nib];
      end else if (d[k]) begin
        o.an = ~(4'(1) << k);
      end
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, queue expectation.
  task automatic step(input bit upd, input logic [15:0] v, input logic [3:0] d);
    update = upd;
    value  = v;
    dp_in  = d;
    @(posedge clk);
    #1;
    if (rst) begin
      n_cyc = 0; m_val = 16'h0; m_dp = 4'h0; m_pend = 1'b0; m_pval = 16'h0; m_pdp = 4'h0;
    end else begin
      n_cyc++;
      if (n_cyc % FRAME == 0) begin
        if (upd) begin
          m_val = v; m_dp = d;
        end else if (m_pend) begin
          m_val = m_pval; m_dp = m_pdp;
        end
        m_pend = 1'b0;
      end else if (upd) begin
        m_pend = 1'b1; m_pval = v; m_pdp = d;
      end
    end
    exp_q.push_back(model_out(n_cyc, m_val, m_dp));
    update = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 16'h0, 4'h0);
  endtask

  // Advance until the last edge lands on frame position p.
  task automatic goto_p(input int p);
    for (int i = 0; i < FRAME && int'(n_cyc % FRAME) != p; i++) step(1'b0, 16'h0, 4'h0);
  endtask

  // Assert reset between edges and check the pins respond without a clock.
  task automatic reset_mid();
    #2;
    exp_q.delete();
    rst = 1'b1;
    #1;
    check("async_reset", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
    step(1'b0, 16'h0, 4'h0);
    step(1'b0, 16'h0, 4'h0);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: one expectation per cycle, compared at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = '{an: an, seg: seg, dp: dp, fd: frame_done};
        n_tests++;
        if (mon_a !== mon_e) begin
          n_fail++;
          $display("FAIL pins@%0t: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                   $time, mon_a.an, mon_a.seg, mon_a.dp, mon_a.fd,
                   mon_e.an, mon_e.seg, mon_e.dp, mon_e.fd);
        end
      end
    end
  end

  // Anode overlap and blank-segment invariants every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      n_tests++;
      if (($countones(~an) > 1) || (an == 4'hF && seg != 7'h7F)) begin
        n_fail++;
        $display("FAIL overlap@%0t: got an=%b seg=%b, expected at most one anode low and blank seg when all off",
                 $time, an, seg);
      end
    end
  end

  int fd_at;

  initial begin
    step(1'b0, 16'h0, 4'h0);
    step(1'b0, 16'h0, 4'h0);
    rst = 1'b0;

    // First frame_done lands 4*RDIV edges after release.
    fd_at = -1;
    for (int i = 0; i < 2 * FRAME && fd_at < 0; i++) begin
      step(1'b0, 16'h0, 4'h0);
      if (frame_done === 1'b1) fd_at = int'(n_cyc);
    end
    check("first_frame_done", fd_at, FRAME);

    // Scan of 1234 with dp on digit 2.
    goto_p(1);
    step(1'b1, 16'h1234, 4'b0100);
    idle(2 * FRAME);

    // Tear-free: mid-frame updates only take effect at the next boundary, last one wins.
    goto_p(3);
    step(1'b1, 16'hAAAA, 4'h0);
    goto_p(0);
    goto_p(9);
    step(1'b1, 16'h5555, 4'h1);
    goto_p(19);
    step(1'b1, 16'h0F0F, 4'h2);
    goto_p(0);
    idle(FRAME);

    // Update on the boundary edge overrides an older pending request.
    goto_p(5);
    step(1'b1, 16'h1111, 4'h8);
    goto_p(FRAME - 1);
    step(1'b1, 16'hBEEF, 4'h0);
    idle(2 * FRAME);

    // Leading-zero cases.
    goto_p(FRAME - 1);
    step(1'b1, 16'h0005, 4'h0);
    idle(FRAME);
    goto_p(FRAME - 1);
    step(1'b1, 16'h0000, 4'b0010);
    idle(FRAME + 4);

    // Reset mid-slot discards a pending request and restarts at digit 0.
    goto_p(8);
    step(1'b1, 16'hCAFE, 4'hF);
    goto_p(13);
    reset_mid();
    idle(2 * FRAME + 3);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 20 * FRAME; i++) begin
      if ($urandom_range(0, 299) == 0) reset_mid();
      else step($urandom_range(0, 9) == 0, 16'($urandom), 4'($urandom));
    end

    idle(2);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
